// File: rtl/reg_file_pkg.sv
// Shared constants for the architectural register file: register index,
// data and ROB position widths.
package reg_file_pkg;

  localparam int REG_COUNT = 32;
  localparam int REG_IDX_W = 5;
  localparam int XLEN      = 32;
  localparam int ROB_TAG_W = 4;

endpackage : reg_file_pkg

// File: rtl/reg_file.sv
// Architectural register file with per-register rename tags (busy + ROB position).
// Decoder reads operands and renames destinations; the ROB commit port retires values.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int REG_NUM   = REG_COUNT,
  parameter int ROB_POS_W = ROB_TAG_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 rollback,
  input  logic                 issue,
  input  logic [REG_IDX_W-1:0] issue_rd,
  input  logic [ROB_POS_W-1:0] issue_rob_pos,
  input  logic                 reg_write,
  input  logic [REG_IDX_W-1:0] reg_rd,
  input  logic [XLEN-1:0]      reg_val,
  input  logic [ROB_POS_W-1:0] commit_rob_pos,
  input  logic [REG_IDX_W-1:0] rs1,
  output logic [XLEN-1:0]      rs1_val,
  output logic                 rs1_busy,
  output logic [ROB_POS_W-1:0] rs1_rob_pos,
  input  logic [REG_IDX_W-1:0] rs2,
  output logic [XLEN-1:0]      rs2_val,
  output logic                 rs2_busy,
  output logic [ROB_POS_W-1:0] rs2_rob_pos
);

  logic [XLEN-1:0]      val_q [REG_NUM];
  logic [ROB_POS_W-1:0] tag_q [REG_NUM];
  logic [REG_NUM-1:0]   busy_q;

  logic commit_en;
  logic issue_en;
  logic commit_clears;
  logic rs1_hit;
  logic rs2_hit;

  assign commit_en = reg_write && (reg_rd != '0);
  assign issue_en  = issue && !rollback && (issue_rd != '0);

  // A commit only retires the tag it owns; a same-cycle rename of the register is younger.
  assign commit_clears = commit_en && busy_q[reg_rd] && (tag_q[reg_rd] == commit_rob_pos)
                         && !(issue_en && (issue_rd == reg_rd));

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the storage array is reset explicitly because reads after reset must return 0.
      for (int i = 0; i < REG_NUM; i++) begin
        val_q[i] <= '0;
        tag_q[i] <= '0;
      end
      busy_q <= '0;
    end else if (rdy) begin
      // NOTE: non-blocking assignments; the later issue update overrides the commit clear.
      if (commit_en) begin
        val_q[reg_rd] <= reg_val;
        if (commit_clears) busy_q[reg_rd] <= 1'b0;
      end
      if (rollback) begin
        busy_q <= '0;
      end else if (issue_en) begin
        busy_q[issue_rd] <= 1'b1;
        tag_q[issue_rd]  <= issue_rob_pos;
      end
    end
  end

  // Bypass sees pre-issue state; the Decoder handles its own rd==rs hazard.
  assign rs1_hit = reg_write && (reg_rd == rs1) && busy_q[rs1] && (tag_q[rs1] == commit_rob_pos);
  assign rs2_hit = reg_write && (reg_rd == rs2) && busy_q[rs2] && (tag_q[rs2] == commit_rob_pos);

  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    rs1_val     = val_q[rs1];
    rs1_busy    = busy_q[rs1];
    rs1_rob_pos = tag_q[rs1];
    if (rs1 == '0) begin
      rs1_val     = '0;
      rs1_busy    = 1'b0;
      rs1_rob_pos = '0;
    end else if (rs1_hit) begin
      rs1_val  = reg_val;
      rs1_busy = 1'b0;
    end
  end

  always_comb begin
    rs2_val     = val_q[rs2];
    rs2_busy    = busy_q[rs2];
    rs2_rob_pos = tag_q[rs2];
    if (rs2 == '0) begin
      rs2_val     = '0;
      rs2_busy    = 1'b0;
      rs2_rob_pos = '0;
    end else if (rs2_hit) begin
      rs2_val  = reg_val;
      rs2_busy = 1'b0;
    end
  end

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: behavioural register model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        rollback;
  logic        issue;
  logic [4:0]  issue_rd;
  logic [3:0]  issue_rob_pos;
  logic        reg_write;
  logic [4:0]  reg_rd;
  logic [31:0] reg_val;
  logic [3:0]  commit_rob_pos;
  logic [4:0]  rs1;
  logic [31:0] rs1_val;
  logic        rs1_busy;
  logic [3:0]  rs1_rob_pos;
  logic [4:0]  rs2;
  logic [31:0] rs2_val;
  logic        rs2_busy;
  logic [3:0]  rs2_rob_pos;

  int checks = 0;
  int errors = 0;

  // Architectural view of the file: one value, one busy flag, one owner per register.
  logic [31:0] m_val  [32];
  logic        m_busy [32];
  logic [3:0]  m_tag  [32];

  always #5 clk = ~clk;

  reg_file dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .issue(issue), .issue_rd(issue_rd), .issue_rob_pos(issue_rob_pos),
    .reg_write(reg_write), .reg_rd(reg_rd), .reg_val(reg_val),
    .commit_rob_pos(commit_rob_pos),
    .rs1(rs1), .rs1_val(rs1_val), .rs1_busy(rs1_busy), .rs1_rob_pos(rs1_rob_pos),
    .rs2(rs2), .rs2_val(rs2_val), .rs2_busy(rs2_busy), .rs2_rob_pos(rs2_rob_pos)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each register decides its own next state from the rules of a cycle.
  always @(posedge clk) begin
    for (int r = 0; r < 32; r++) begin
      if (rst) begin
        m_val[r]  <= 32'h0;
        m_busy[r] <= 1'b0;
        m_tag[r]  <= 4'h0;
      end else if (rdy && r != 0) begin
        if (reg_write && reg_rd == r) begin
          m_val[r] <= reg_val;
          if (m_busy[r] && m_tag[r] == commit_rob_pos) m_busy[r] <= 1'b0;
        end
        if (rollback) m_busy[r] <= 1'b0;
        else if (issue && issue_rd == r) begin
          m_busy[r] <= 1'b1;
          m_tag[r]  <= issue_rob_pos;
        end
      end
    end
  end

  function automatic void model_read(input logic [4:0] rs, output logic [31:0] v,
                                     output logic b, output logic [3:0] p);
    v = m_val[rs];
    b = m_busy[rs];
    p = m_tag[rs];
    if (rs == 5'd0) begin
      v = 32'h0;
      b = 1'b0;
      p = 4'h0;
    end else if (reg_write && reg_rd == rs && m_busy[rs] && m_tag[rs] == commit_rob_pos) begin
      v = reg_val;
      b = 1'b0;
    end
  endfunction

  always @(negedge clk) begin
    logic [31:0] ev;
    logic        eb;
    logic [3:0]  ep;
    if (!rst) begin
      model_read(rs1, ev, eb, ep);
      check("model rs1_val", rs1_val, ev);
      check("model rs1_busy", {31'h0, rs1_busy}, {31'h0, eb});
      if (eb) check("model rs1_rob_pos", {28'h0, rs1_rob_pos}, {28'h0, ep});
      model_read(rs2, ev, eb, ep);
      check("model rs2_val", rs2_val, ev);
      check("model rs2_busy", {31'h0, rs2_busy}, {31'h0, eb});
      if (eb) check("model rs2_rob_pos", {28'h0, rs2_rob_pos}, {28'h0, ep});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rdy       = 1'b1;
    rollback  = 1'b0;
    issue     = 1'b0;
    reg_write = 1'b0;
  endtask

  task automatic do_issue(input logic [4:0] rd, input logic [3:0] pos);
    issue         = 1'b1;
    issue_rd      = rd;
    issue_rob_pos = pos;
  endtask

  task automatic do_commit(input logic [4:0] rd, input logic [3:0] pos, input logic [31:0] v);
    reg_write      = 1'b1;
    reg_rd         = rd;
    commit_rob_pos = pos;
    reg_val        = v;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    issue_rd = '0; issue_rob_pos = '0;
    reg_rd = '0; reg_val = '0; commit_rob_pos = '0;
    rs1 = '0; rs2 = '0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    rs1 = 5'd5; rs2 = 5'd0;
    @(negedge clk);
    check("reset rs1_val", rs1_val, 32'h0);
    check("reset rs1_busy", {31'h0, rs1_busy}, 32'h0);
    check("reset rs2_val", rs2_val, 32'h0);
    check("reset rs2_busy", {31'h0, rs2_busy}, 32'h0);

    // Rename then commit with bypass
    step(); do_issue(5'd3, 4'd7);
    step(); idle(); rs1 = 5'd3;
    @(negedge clk);
    check("issue x3 busy", {31'h0, rs1_busy}, 32'h1);
    check("issue x3 pos", {28'h0, rs1_rob_pos}, 32'h7);
    step(); do_commit(5'd3, 4'd7, 32'hDEADBEEF);
    @(negedge clk);
    check("bypass x3 val", rs1_val, 32'hDEADBEEF);
    check("bypass x3 busy", {31'h0, rs1_busy}, 32'h0);
    step(); idle();
    @(negedge clk);
    check("stored x3 val", rs1_val, 32'hDEADBEEF);
    check("stored x3 busy", {31'h0, rs1_busy}, 32'h0);

    // Older commit must not clear a younger rename
    step(); do_issue(5'd4, 4'd2);
    step(); do_issue(5'd4, 4'd5);
    step(); idle(); do_commit(5'd4, 4'd2, 32'h11);
    step(); idle(); rs1 = 5'd4;
    @(negedge clk);
    check("stale commit x4 val", rs1_val, 32'h11);
    check("stale commit x4 busy", {31'h0, rs1_busy}, 32'h1);
    check("stale commit x4 pos", {28'h0, rs1_rob_pos}, 32'h5);

    // Same-cycle issue and matching commit: rename wins
    step(); do_issue(5'd6, 4'd1);
    step(); do_issue(5'd6, 4'd9); do_commit(5'd6, 4'd1, 32'h22);
    step(); idle(); rs1 = 5'd6;
    @(negedge clk);
    check("issue+commit x6 val", rs1_val, 32'h22);
    check("issue+commit x6 busy", {31'h0, rs1_busy}, 32'h1);
    check("issue+commit x6 pos", {28'h0, rs1_rob_pos}, 32'h9);

    // Rollback with a concurrent commit write and an ignored issue
    step(); do_issue(5'd8, 4'd3);
    step(); do_issue(5'd9, 4'd4);
    step(); rollback = 1'b1; do_issue(5'd10, 4'd6); do_commit(5'd8, 4'd0, 32'h33);
    step(); idle(); rs1 = 5'd8; rs2 = 5'd9;
    @(negedge clk);
    check("rollback x8 val", rs1_val, 32'h33);
    check("rollback x8 busy", {31'h0, rs1_busy}, 32'h0);
    check("rollback x9 busy", {31'h0, rs2_busy}, 32'h0);
    step(); rs1 = 5'd10; rs2 = 5'd6;
    @(negedge clk);
    check("rollback x10 busy", {31'h0, rs1_busy}, 32'h0);
    check("rollback x6 busy", {31'h0, rs2_busy}, 32'h0);

    // x0 is hardwired
    step(); do_issue(5'd0, 4'd5); do_commit(5'd0, 4'd5, 32'h44); rs1 = 5'd0;
    step(); idle();
    @(negedge clk);
    check("x0 val", rs1_val, 32'h0);
    check("x0 busy", {31'h0, rs1_busy}, 32'h0);

    // rdy=0 freezes state
    step(); rdy = 1'b0; do_issue(5'd12, 4'd2); do_commit(5'd13, 4'd0, 32'h55);
    step();
    step(); idle(); rs1 = 5'd12; rs2 = 5'd13;
    @(negedge clk);
    check("stall x12 busy", {31'h0, rs1_busy}, 32'h0);
    check("stall x13 val", rs2_val, 32'h0);

    // Commit held across a stall is idempotent
    step(); do_issue(5'd13, 4'd8);
    step(); idle(); rdy = 1'b0; do_commit(5'd13, 4'd8, 32'h66); rs1 = 5'd13;
    @(negedge clk);
    check("stall bypass x13 val", rs1_val, 32'h66);
    step();
    step(); rdy = 1'b1;
    step(); idle();
    @(negedge clk);
    check("repeat commit x13 val", rs1_val, 32'h66);
    check("repeat commit x13 busy", {31'h0, rs1_busy}, 32'h0);

    step();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_reg_file

// File: doc/reg_file.md
Name: reg_file

Overview:
- Architectural register file with per-register rename tags (busy bit + ROB position).
- Sits between the Decoder and the commit stage of the Reorder Buffer.
- Decoder reads operands and learns whether each operand is final or must wait on a ROB entry.
- Decoder marks a destination busy at issue; the ROB commit port writes final values and clears the tags.

Parameters:
REG_NUM, 32, number of architectural registers (x0..x31)
ROB_POS_W, 4, width of a ROB position tag (16 entries)

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
rdy  input  1  global ready; state holds when low
rollback  input  1  ROB flush; clears all rename tags
issue  input  1  Decoder issues an instruction this cycle
issue_rd  input  5  destination register of the issued instruction
issue_rob_pos  input  ROB_POS_W  ROB entry allocated to the issued instruction
reg_write  input  1  ROB commit write strobe
reg_rd  input  5  commit destination register
reg_val  input  32  commit value
commit_rob_pos  input  ROB_POS_W  ROB entry being committed
rs1  input  5  source register 1 index
rs1_val  output  32  value of rs1 (valid when rs1_busy=0)
rs1_busy  output  1  rs1 awaits a ROB result
rs1_rob_pos  output  ROB_POS_W  ROB entry producing rs1 (valid when rs1_busy=1)
rs2  input  5  source register 2 index
rs2_val  output  32  value of rs2
rs2_busy  output  1  rs2 awaits a ROB result
rs2_rob_pos  output  ROB_POS_W  ROB entry producing rs2

Behaviour:
- State per register: val[32], busy[1], tag[ROB_POS_W].
- Reset (rst=1 at posedge): all val=0, busy=0, tag=0. Read outputs are combinational, so rsX_val=0 and rsX_busy=0 after reset.
- rdy=0: no state update. Reads remain combinational.
- Commit write (rdy=1, reg_write=1, reg_rd!=0):
  - val[reg_rd] <= reg_val on the next edge.
  - busy[reg_rd] <= 0 only if busy[reg_rd]=1 and tag[reg_rd]==commit_rob_pos and no same-cycle issue renames reg_rd.
  - Otherwise the tag stays, because a younger writer owns the register.
- Issue (rdy=1, issue=1, rollback=0, issue_rd!=0): busy[issue_rd] <= 1 and tag[issue_rd] <= issue_rob_pos.
- Same cycle, same register for issue and commit: the value is written and the issue rename wins (busy=1, new tag).
- Rollback (rdy=1, rollback=1):
  - All busy <= 0.
  - The issue input is ignored.
  - A concurrent reg_write is still applied, because the ROB raises rollback and the JALR write in the same cycle.
- x0: reads always return val=0, busy=0, tag=0. Writes and issues to x0 are dropped.
- Read bypass (combinational, per source port):
  - Condition: rsX!=0, reg_write=1, reg_rd==rsX, busy[rsX]=1, tag[rsX]==commit_rob_pos.
  - Response: rsX_val=reg_val, rsX_busy=0.
  - The bypass reflects state before this cycle's issue. The Decoder resolves its own rd==rs hazard separately.
- Without bypass: rsX_val=val[rsX], rsX_busy=busy[rsX], rsX_rob_pos=tag[rsX].
- Latency: writes become visible in storage one cycle after the strobe and immediately via the bypass. Reads have zero cycles of latency.
- A repeated reg_write across rdy=0 stalls is idempotent.

Decomposition:
- Shared package (existing constant include): ROB_POS_W and the register-index width of 5.
- No sub-module; a single flat module with an always block and combinational read muxes.

Test Plan:
- Reset, then read rs1=5, rs2=0 -> rs1_val=0, rs1_busy=0, rs2_val=0, rs2_busy=0.
- Issue rd=3, rob_pos=7; next cycle read rs1=3 -> busy=1, rob_pos=7. Then commit reg_rd=3, pos=7, val=0xDEADBEEF -> same-cycle read gives val=0xDEADBEEF, busy=0; next cycle storage shows the same.
- Issue rd=4 pos=2, then issue rd=4 pos=5; commit rd=4 pos=2 val=0x11 -> busy stays 1, tag=5, val=0x11.
- Same cycle: issue rd=6 pos=9 and commit rd=6 pos=1 (tag matching) val=0x22 -> val=0x22, busy=1, tag=9.
- Busy on x8 and x9, then rollback=1 with reg_write rd=8 val=0x33 and issue rd=10 -> all busy=0, x8=0x33, x10 not busy.
- Issue and commit to x0 with val=0x44 -> x0 reads val=0, busy=0. With rdy=0, an issue/commit pulse -> no state change.
